// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_pkg
//  Description : Shared state encoding and line constants for the FIFO-fed
//                UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_uart_pkg;

    // Transmitter state encoding; PARITY is only reachable when parity is built in
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Level of the serial line when no frame is being sent (UART mark)
    localparam logic c_tx_idle_level = 1'b1;

endpackage : fifo_uart_pkg
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : baud_tick_gen
//  Description : Bit-period timer. Counts 0..CLKS_PER_BIT-1 and pulses tick on
//                the last cycle of each bit period; restart holds it at zero so
//                the first period after restart is a full one.
//  Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int                 c_cnt_w    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Baud counter: reloads at every bit boundary, parked at zero on restart
    always_ff @(posedge clk) begin
        if (rst || restart || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_cnt_last);

endmodule : baud_tick_gen
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : Read-side FIFO consumer. Pops one word from a show-ahead FIFO
//                whenever it is idle and the FIFO is not empty, then sends it
//                as a UART frame: start, DATA_WIDTH bits LSB-first, optional
//                even parity, one stop bit.
//                Build option: define FIFO_UART_TX_PARITY_EN to insert the
//                even-parity bit between the data bits and the stop bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int                     c_bit_cnt_w = $clog2(DATA_WIDTH) + 1;
    localparam logic [c_bit_cnt_w-1:0] c_last_bit  = c_bit_cnt_w'(DATA_WIDTH - 1);

    tx_state_t               r_state;
    tx_state_t               w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [c_bit_cnt_w-1:0]  r_bit_cnt;
    logic                    r_tx;
    logic                    r_busy;
    logic                    r_frame_done;
    logic                    w_pop;
    logic                    w_tick;
    logic                    w_restart;
    logic                    w_last_bit;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                    r_parity;
`endif

    // The bit timer only runs while a frame is in flight
    assign w_restart  = (r_state == ST_IDLE);
    assign w_last_bit = (r_bit_cnt == c_last_bit);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // Next-state and pop decision; the pop is combinational so the word is
    // taken on the same edge that leaves IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!fifo_empty && !rst) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick && w_last_bit) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    w_state_nxt = ST_STOP;
`endif
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift register and bit counter: load on pop, advance at each data-bit boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_pop) begin
            r_shift   <= fifo_data;
            r_bit_cnt <= '0;
        end else if ((r_state == ST_DATA) && w_tick) begin
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= w_last_bit ? '0 : (r_bit_cnt + 1'b1);
        end
    end

`ifdef FIFO_UART_TX_PARITY_EN
    // Parity is taken from the whole word at pop time, before the shifts destroy it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^fifo_data;
        end
    end
`endif

    // Registered line and status outputs, each reflecting the state one cycle late
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx         <= c_tx_idle_level;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_busy       <= (r_state != ST_IDLE);
            r_frame_done <= (r_state == ST_STOP) && w_tick;
            case (r_state)
                ST_START:  r_tx <= 1'b0;
                ST_DATA:   r_tx <= r_shift[0];
`ifdef FIFO_UART_TX_PARITY_EN
                ST_PARITY: r_tx <= r_parity;
`endif
                default:   r_tx <= c_tx_idle_level;
            endcase
        end
    end

    assign fifo_r_en  = w_pop;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule : fifo_uart_tx
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fifo_uart_tx
//  Description : Bench for fifo_uart_tx. A queue stands in for the show-ahead
//                FIFO; every pushed word is also queued as an expected frame
//                and a serial monitor checks each frame bit by bit.
//                Honours FIFO_UART_TX_PARITY_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif
    localparam int FCYC = NBITS * CPB;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data  = '0;
    logic          fifo_r_en;
    logic          tx;
    logic          busy;
    logic          frame_done;

    fifo_uart_tx #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int             n_cmp     = 0;
    int             n_bad     = 0;
    int             cyc       = 0;
    int             pops      = 0;
    int             n_push    = 0;
    int             last_pop  = -100;
    int             spurious  = 0;
    int             idle_err  = 0;
    logic           pend      = 1'b0;
    logic           abort_req = 1'b0;
    logic           in_frame  = 1'b0;
    logic [DW-1:0]  fq[$];
    logic [DW-1:0]  ewq[$];
    int             pop_edges[$];
    logic [NBITS-1:0] ebits;
    int             pos;
    logic           cur;
    logic [DW-1:0]  junk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        ewq.push_back(w);
        n_push++;
    endtask

    // Reference frame: start 0, data LSB first, even parity if built, stop 1
    function automatic logic [NBITS-1:0] frame_of(input logic [DW-1:0] w);
        logic [NBITS-1:0] f;
        int ones;
        ones = 0;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DW; i++) begin
            f[1+i] = w[i];
            ones += int'(w[i]);
        end
`ifdef FIFO_UART_TX_PARITY_EN
        f[DW+1] = ((ones % 2) == 1);
`endif
        return f;
    endfunction

    // FIFO model: pop on the edge after r_en was seen, then present the next head
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (pend) begin
                pend     = 1'b0;
                pops++;
                last_pop = cyc;
                pop_edges.push_back(cyc);
                if (fq.size() > 0) junk = fq.pop_front();
            end
            #1;
            fifo_empty = (fq.size() == 0);
            fifo_data  = fifo_empty ? DW'($urandom) : fq[0];
        end
    end

    // Monitor: r_en legality, frame decoding against the expected-word queue
    always @(negedge clk) begin
        logic ended;
        logic aborted;
        ended   = 1'b0;
        aborted = 1'b0;
        if (fifo_r_en === 1'b1) begin
            pend = 1'b1;
            if (fifo_empty || rst) spurious++;
        end
        if (abort_req) begin
            abort_req = 1'b0;
            in_frame  = 1'b0;
            aborted   = 1'b1;
        end
        if (in_frame && pos == FCYC) begin
            check("busy_after_frame", busy, 0);
            in_frame = 1'b0;
            ended    = 1'b1;
        end
        if (!in_frame && !ended && !aborted && !rst && tx === 1'b0) begin
            check("word_pending_at_start", ewq.size() > 0, 1);
            if (ewq.size() > 0) begin
                ebits    = frame_of(ewq.pop_front());
                check("pop_to_start_latency", cyc - last_pop, 1);
                in_frame = 1'b1;
                pos      = 0;
            end
        end
        if (in_frame && pos < FCYC) begin
            if (pos % CPB == 0) cur = tx;
            if (tx !== ebits[pos/CPB]) cur = tx;
            if (busy !== 1'b1) idle_err++;
            if (pos == FCYC - 1) check("frame_done_last_stop", frame_done, 1);
            else if (frame_done !== 1'b0) idle_err++;
            if (pos % CPB == CPB - 1) check($sformatf("frame_bit%0d", pos / CPB), cur, ebits[pos/CPB]);
            pos++;
        end else if (!in_frame && !ended && !aborted && !rst) begin
            if (busy !== 1'b0 || frame_done !== 1'b0) idle_err++;
        end
    end

    task automatic wait_idle(input int max_cyc);
        int k;
        k = 0;
        while (!(fq.size() == 0 && ewq.size() == 0 && !in_frame && busy === 1'b0) && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check("drain_in_budget", (k < max_cyc), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n0;
        int p0;
        int bad;
        int k;

        // Reset held with a word waiting: no pop, idle line
        rst = 1'b1;
        @(negedge clk);
        push(8'hA5);
        repeat (3) begin
            @(negedge clk);
            check("rst_r_en", fifo_r_en, 0);
            check("rst_tx", tx, 1);
            check("rst_busy", busy, 0);
            check("rst_frame_done", frame_done, 0);
        end
        rst = 1'b0;
        wait_idle(200);
        check("single_word_pops", pops, 1);

        // Back-to-back words
        n0 = pop_edges.size();
        @(negedge clk);
        push(8'h00);
        push(8'hFF);
        wait_idle(300);
        check("b2b_pops", pop_edges.size() - n0, 2);
        if (pop_edges.size() >= n0 + 2)
            check("b2b_pop_gap", pop_edges[n0+1] - pop_edges[n0], FCYC + 1);

        // Empty hold
        p0  = pops;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_r_en !== 1'b0) bad++;
        end
        check("empty_hold_glitches", bad, 0);
        check("empty_hold_pops", pops - p0, 0);

        // Reset during data bit 3
        @(negedge clk);
        push(8'h3C);
        k = 0;
        while (!in_frame && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("midrst_frame_started", in_frame, 1);
        repeat (CPB + 3 * CPB + 1) @(negedge clk);
        rst       = 1'b1;
        abort_req = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_r_en", fifo_r_en, 0);
        @(negedge clk);
        rst = 1'b0;
        p0  = pops;
        repeat (60) @(negedge clk);
        check("midrst_no_repop", pops - p0, 0);
        check("midrst_line_idle", tx, 1);

        // Parity-relevant words (plain frames when parity is not built)
        @(negedge clk);
        push(8'h07);
        wait_idle(200);
        @(negedge clk);
        push(8'h03);
        wait_idle(200);

        // Random traffic
        for (int it = 0; it < 25; it++) begin
            @(negedge clk);
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) push(DW'($urandom));
            repeat ($urandom_range(0, 50)) @(negedge clk);
        end
        wait_idle(3000);

        check("spurious_r_en", spurious, 0);
        check("idle_status_glitches", idle_err, 0);
        check("expected_words_left", ewq.size(), 0);
        check("pops_total", pops, n_push);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule : tb_fifo_uart_tx
`default_nettype wire
